adder_bist_ctrl: RTL and testbench

- Built-in self-test controller for the N-bit ripple adder.
- Drives the test-side inputs and the select line of the adder's 2-to-1 input mux, generating pseudo-random operand/carry patterns from an LFSR.
- Compacts the adder's sum/carry-out into a MISR and compares the final signature against a golden value.
- Sits between the test-access logic (start/abort) and the adder's input mux and output.

---
 rtl/adder_bist_ctrl.sv | 138 +++++++++++++
 tb/tb_adder_bist_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_bist_ctrl.sv
// ============================================================================
//  Module      : adder_bist_ctrl
//  Description : Built-in self-test controller for an N-bit ripple adder.
//                An LFSR generates operand/carry patterns and a MISR compacts
//                the adder's results into a signature for the pass/fail check.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_bist_ctrl #(
    parameter int           N          = 16,
    parameter int           PATTERNS   = 256,
    parameter logic [2*N:0] LFSR_TAPS  = 33'h1_0008_0000,
    parameter logic [2*N:0] LFSR_SEED  = 33'h0_0000_0001,
    parameter logic [N:0]   MISR_TAPS  = 17'h1_2000,
    parameter logic [N:0]   GOLDEN_SIG = 17'h0_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bist_start,
    input  logic         bist_abort,
    output logic [N-1:0] test_a,
    output logic [N-1:0] test_b,
    output logic         test_cin,
    output logic         test_sel,
    input  logic [N-1:0] dut_sum,
    input  logic         dut_cout,
    output logic         bist_busy,
    output logic         bist_done,
    output logic         bist_pass,
    output logic [N:0]   signature
);

    localparam int c_cnt_w = (PATTERNS > 1) ? $clog2(PATTERNS) : 1;

    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(PATTERNS - 1);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [2*N:0] c_seed =
        (LFSR_SEED == '0) ? {{(2*N){1'b0}}, 1'b1} : LFSR_SEED;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic               r_start_q;
    logic [2*N:0]       r_lfsr;
    logic [N:0]         r_misr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_sel;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;

    logic               w_start_pulse;
    logic               w_run;
    logic [2*N:0]       w_lfsr_next;
    logic [N:0]         w_misr_next;

    assign w_start_pulse = bist_start & ~r_start_q;
    assign w_run         = (r_state == c_st_run);

    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
    assign w_misr_next = (r_misr >> 1) ^ (r_misr[0] ? MISR_TAPS : '0)
                       ^ {dut_cout, dut_sum};

    // The adder is combinational, so the current pattern is captured every RUN cycle.
    assign test_a    = w_run ? r_lfsr[N-1:0]   : '0;
    assign test_b    = w_run ? r_lfsr[2*N-1:N] : '0;
    assign test_cin  = w_run ? r_lfsr[2*N]     : 1'b0;
    assign test_sel  = r_sel;
    assign bist_busy = r_busy;
    assign bist_done = r_done;
    assign bist_pass = r_pass;
    assign signature = r_misr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_start_q <= 1'b0;
            r_lfsr    <= '0;
            r_misr    <= '0;
            r_count   <= '0;
            r_sel     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_start_q <= bist_start;
            if (bist_abort) begin
                // LFSR and MISR are left untouched so they can be inspected.
                r_state <= c_st_idle;
                r_sel   <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
                r_pass  <= 1'b0;
            end else begin
                case (r_state)
                    c_st_idle, c_st_done: begin
                        if (w_start_pulse) begin
                            r_state <= c_st_run;
                            r_lfsr  <= c_seed;
                            r_misr  <= '0;
                            r_count <= '0;
                            r_sel   <= 1'b1;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_pass  <= 1'b0;
                        end
                    end
                    c_st_run: begin
                        r_misr  <= w_misr_next;
                        r_lfsr  <= w_lfsr_next;
                        r_count <= r_count + 1'b1;
                        if (r_count == c_last_cnt) begin
                            r_state <= c_st_done;
                            r_sel   <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_misr_next == GOLDEN_SIG);
                        end
                    end
                    default: begin
                        r_state <= c_st_idle;
                        r_sel   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adder_bist_ctrl.sv
// ============================================================================
//  Module      : tb_adder_bist_ctrl
//  Description : Directed self-checking bench for adder_bist_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_bist_ctrl;

    function automatic logic [16:0] model_sig(input int n, input logic stuck);
        logic [32:0] l;
        logic [16:0] m;
        logic [16:0] s;
        l = 33'h1;
        m = 17'h0;
        for (int i = 0; i < n; i++) begin
            s = {1'b0, l[15:0]} + {1'b0, l[31:16]} + {16'h0, l[32]};
            if (stuck) s[7] = 1'b0;
            m = (m >> 1) ^ (m[0] ? 17'h1_2000 : 17'h0) ^ s;
            l = (l >> 1) ^ (l[0] ? 33'h1_0008_0000 : 33'h0);
        end
        return m;
    endfunction

    localparam logic [16:0] GOLD = model_sig(256, 1'b0);

    logic        clk;
    logic        rst;
    logic        bist_start;
    logic        bist_abort;
    logic        fault;
    logic [15:0] test_a, test_b, dut_sum;
    logic        test_cin, test_sel, dut_cout;
    logic        bist_busy, bist_done, bist_pass;
    logic [16:0] signature;

    logic        start_s;
    logic [3:0]  s_a, s_b, s_sum;
    logic        s_cin, s_sel, s_cout, s_busy, s_done, s_pass;
    logic [4:0]  s_sig;

    int checks = 0;
    int errors = 0;
    int cyc;

    always_comb begin
        {dut_cout, dut_sum} = {1'b0, test_a} + {1'b0, test_b} + {16'h0, test_cin};
        if (fault) dut_sum[7] = 1'b0;
    end

    assign {s_cout, s_sum} = {1'b0, s_a} + {1'b0, s_b} + {4'h0, s_cin};

    adder_bist_ctrl #(
        .N(16), .PATTERNS(256), .LFSR_TAPS(33'h1_0008_0000),
        .LFSR_SEED(33'h0_0000_0001), .MISR_TAPS(17'h1_2000), .GOLDEN_SIG(GOLD)
    ) u_dut (
        .clk(clk), .rst(rst), .bist_start(bist_start), .bist_abort(bist_abort),
        .test_a(test_a), .test_b(test_b), .test_cin(test_cin), .test_sel(test_sel),
        .dut_sum(dut_sum), .dut_cout(dut_cout), .bist_busy(bist_busy),
        .bist_done(bist_done), .bist_pass(bist_pass), .signature(signature)
    );

    adder_bist_ctrl #(
        .N(4), .PATTERNS(4), .LFSR_TAPS(9'h110), .LFSR_SEED(9'h001),
        .MISR_TAPS(5'h12), .GOLDEN_SIG(5'h00)
    ) u_small (
        .clk(clk), .rst(rst), .bist_start(start_s), .bist_abort(bist_abort),
        .test_a(s_a), .test_b(s_b), .test_cin(s_cin), .test_sel(s_sel),
        .dut_sum(s_sum), .dut_cout(s_cout), .bist_busy(s_busy),
        .bist_done(s_done), .bist_pass(s_pass), .signature(s_sig)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts busy cycles until done; an expired bound is reported as a failure.
    task automatic run_to_done(input string tag, output int n);
        n = 0;
        while (bist_busy && n < 1000) begin
            n++;
            tick();
        end
        check({tag, "_timeout"}, 64'(bist_done), 64'd1);
    endtask

    initial begin
        rst        = 1'b1;
        bist_start = 1'b0;
        bist_abort = 1'b0;
        start_s    = 1'b0;
        fault      = 1'b0;
        #3;
        check("rst_sel",  64'(test_sel),  64'd0);
        check("rst_busy", 64'(bist_busy), 64'd0);
        check("rst_done", 64'(bist_done), 64'd0);
        check("rst_pass", 64'(bist_pass), 64'd0);
        check("rst_sig",  64'(signature), 64'd0);
        check("rst_a",    64'(test_a),    64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Short LFSR sequence on the 4-bit instance
        start_s = 1'b1;
        tick();
        check("pat1_sel", 64'(s_sel), 64'd1);
        check("pat1", 64'({s_a, s_b, s_cin}), 64'({4'h1, 4'h0, 1'b0}));
        tick();
        check("pat2", 64'({s_a, s_b, s_cin}), 64'({4'h0, 4'h1, 1'b1}));
        tick();
        check("pat3", 64'({s_a, s_b, s_cin}), 64'({4'h8, 4'h8, 1'b0}));
        start_s = 1'b0;

        // Golden run
        bist_start = 1'b1;
        tick();
        check("gold_sel",  64'(test_sel), 64'd1);
        check("gold_pat0", 64'({test_a, test_b, test_cin}), 64'({16'h0001, 16'h0000, 1'b0}));
        run_to_done("gold", cyc);
        check("gold_busy_cycles", 64'(cyc), 64'd256);
        check("gold_pass", 64'(bist_pass), 64'd1);
        check("gold_sig",  64'(signature), 64'(GOLD));
        check("gold_sel_off", 64'(test_sel), 64'd0);
        check("gold_quiet", 64'({test_a, test_b, test_cin}), 64'd0);

        // Held start must not retrigger
        tick();
        tick();
        tick();
        check("hold_busy", 64'(bist_busy), 64'd0);
        check("hold_done", 64'(bist_done), 64'd1);

        // Restart from DONE
        bist_start = 1'b0;
        tick();
        bist_start = 1'b1;
        tick();
        check("restart_busy", 64'(bist_busy), 64'd1);
        check("restart_done", 64'(bist_done), 64'd0);
        check("restart_pass", 64'(bist_pass), 64'd0);
        run_to_done("restart", cyc);
        check("restart_sig",  64'(signature), 64'(GOLD));
        check("restart_pass_end", 64'(bist_pass), 64'd1);

        // Stuck-at-0 on sum bit 7
        bist_start = 1'b0;
        tick();
        fault      = 1'b1;
        bist_start = 1'b1;
        tick();
        run_to_done("fault", cyc);
        check("fault_pass", 64'(bist_pass), 64'd0);
        check("fault_sig_differs", 64'(signature !== GOLD), 64'd1);
        check("fault_sig", 64'(signature), 64'(model_sig(256, 1'b1)));
        fault = 1'b0;

        // Abort colliding with a start edge at pattern 100
        bist_start = 1'b0;
        tick();
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        check("pre_abort_busy", 64'(bist_busy), 64'd1);
        bist_abort = 1'b1;
        bist_start = 1'b1;
        tick();
        check("abort_sel",  64'(test_sel),  64'd0);
        check("abort_busy", 64'(bist_busy), 64'd0);
        check("abort_done", 64'(bist_done), 64'd0);
        check("abort_quiet", 64'({test_a, test_b, test_cin}), 64'd0);
        check("abort_sig_kept", 64'(signature), 64'(model_sig(100, 1'b0)));
        bist_abort = 1'b0;
        bist_start = 1'b0;
        tick();
        check("abort_idle", 64'(bist_busy), 64'd0);
        bist_start = 1'b1;
        tick();
        check("rerun_busy", 64'(bist_busy), 64'd1);
        check("rerun_seed", 64'({test_a, test_b, test_cin}), 64'({16'h0001, 16'h0000, 1'b0}));
        check("rerun_misr", 64'(signature), 64'd0);
        run_to_done("rerun", cyc);
        check("rerun_pass", 64'(bist_pass), 64'd1);
        check("rerun_sig",  64'(signature), 64'(GOLD));

        // Reset in the middle of a run at pattern 10
        bist_start = 1'b0;
        tick();
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("pre_rst_sel", 64'(test_sel), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_sel",  64'(test_sel),  64'd0);
        check("midrst_busy", 64'(bist_busy), 64'd0);
        check("midrst_sig",  64'(signature), 64'd0);
        check("midrst_quiet", 64'({test_a, test_b, test_cin}), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("postrst_done", 64'(bist_done), 64'd0);
        check("postrst_busy", 64'(bist_busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
